// File: rtl/i2s_pkg.sv
// Shared types and widths for the I2S WS control blocks.
package i2s_pkg;

   localparam int unsigned DATA_SIZE_W = 5;
   localparam int unsigned WORD_NUM_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } ws_state_t;

endpackage

// File: rtl/i2s_sync_flop.sv
// Generic N-stage level synchronizer with asynchronous active-low reset.
module i2s_sync_flop #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
      end
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/i2s_ws_ctrl.sv
// Start/stop sequencer and frame-boundary configuration shadow for the I2S WS
// generator; mirrors its bit/slot counters and produces slot/frame strobes.
module i2s_ws_ctrl
   import i2s_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_CNT_W = 16
) (
   input  logic                   sck_i,
   input  logic                   rstn_i,
   input  logic                   cfg_en_i,
   input  logic [DATA_SIZE_W-1:0] cfg_data_size_i,
   input  logic [WORD_NUM_W-1:0]  cfg_word_num_i,
   output logic                   ws_en_o,
   output logic [DATA_SIZE_W-1:0] shd_data_size_o,
   output logic [WORD_NUM_W-1:0]  shd_word_num_o,
   output logic [DATA_SIZE_W-1:0] bit_o,
   output logic [WORD_NUM_W-1:0]  slot_o,
   output logic                   slot_start_o,
   output logic                   frame_start_o,
   output logic                   frame_end_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o,
   output logic                   busy_o
);

   ws_state_t              state;
   logic                   en_s;
   logic                   ws_en;
   logic                   busy;
   logic [DATA_SIZE_W-1:0] shd_ds;
   logic [WORD_NUM_W-1:0]  shd_wn;
   logic [DATA_SIZE_W-1:0] bit_q;
   logic [WORD_NUM_W-1:0]  slot_q;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic                   bit_last;
   logic                   fe;

   i2s_sync_flop #(
      .STAGES (SYNC_STAGES)
   ) u_en_sync (
      .clk  (sck_i),
      .rstn (rstn_i),
      .d    (cfg_en_i),
      .q    (en_s)
   );

   assign bit_last = (bit_q == shd_ds);
   assign fe       = ws_en & bit_last & (slot_q == shd_wn);

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         ws_en     <= 1'b0;
         busy      <= 1'b0;
         shd_ds    <= '0;
         shd_wn    <= '0;
         bit_q     <= '0;
         slot_q    <= '0;
         frame_cnt <= '0;
      end else begin
         // ws_en is high exactly in RUN/DRAIN, so it also qualifies counting
         if (ws_en) begin
            if (bit_last) begin
               bit_q  <= '0;
               slot_q <= (slot_q == shd_wn) ? '0 : slot_q + WORD_NUM_W'(1);
            end else begin
               bit_q  <= bit_q + DATA_SIZE_W'(1);
            end
            if (fe) begin
               frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
         end

         case (state)
            IDLE: begin
               bit_q  <= '0;
               slot_q <= '0;
               if (en_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               shd_ds <= cfg_data_size_i;
               shd_wn <= cfg_word_num_i;
               bit_q  <= '0;
               slot_q <= '0;
               if (en_s) begin
                  state <= RUN;
                  ws_en <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               if (!en_s) begin
                  if (fe) begin
                     state <= IDLE;
                     ws_en <= 1'b0;
                     busy  <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (fe) begin
                  shd_ds <= cfg_data_size_i;
                  shd_wn <= cfg_word_num_i;
               end
            end
            DRAIN: begin
               if (en_s) begin
                  state <= RUN;
               end else if (fe) begin
                  state <= IDLE;
                  ws_en <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ws_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ws_en_o         = ws_en;
   assign busy_o          = busy;
   assign shd_data_size_o = shd_ds;
   assign shd_word_num_o  = shd_wn;
   assign bit_o           = bit_q;
   assign slot_o          = slot_q;
   assign frame_cnt_o     = frame_cnt;
   assign slot_start_o    = ws_en & (bit_q == '0);
   assign frame_start_o   = ws_en & (bit_q == '0) & (slot_q == '0);
   assign frame_end_o     = fe;

endmodule

// File: tb/tb_i2s_ws_ctrl.sv
// Self-checking bench for i2s_ws_ctrl: frame-position model plus directed scenarios.
module tb_i2s_ws_ctrl;

   localparam int unsigned SYNC = 2;
   localparam int unsigned FCW  = 16;

   logic           sck = 1'b0;
   logic           rstn = 1'b0;
   logic           cfg_en = 1'b0;
   logic [4:0]     cfg_ds = 5'd15;
   logic [2:0]     cfg_wn = 3'd1;
   logic           ws_en_o, slot_start_o, frame_start_o, frame_end_o, busy_o;
   logic [4:0]     shd_ds_o, bit_o;
   logic [2:0]     shd_wn_o, slot_o;
   logic [FCW-1:0] frame_cnt_o;

   int checks = 0;
   int failures = 0;

   i2s_ws_ctrl #(
      .SYNC_STAGES (SYNC),
      .FRAME_CNT_W (FCW)
   ) dut (
      .sck_i           (sck),
      .rstn_i          (rstn),
      .cfg_en_i        (cfg_en),
      .cfg_data_size_i (cfg_ds),
      .cfg_word_num_i  (cfg_wn),
      .ws_en_o         (ws_en_o),
      .shd_data_size_o (shd_ds_o),
      .shd_word_num_o  (shd_wn_o),
      .bit_o           (bit_o),
      .slot_o          (slot_o),
      .slot_start_o    (slot_start_o),
      .frame_start_o   (frame_start_o),
      .frame_end_o     (frame_end_o),
      .frame_cnt_o     (frame_cnt_o),
      .busy_o          (busy_o)
   );

   always #5 sck = ~sck;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 start, 2 run, 3 drain; pos = cycle offset inside the frame
   int             m_phase = 0;
   int             m_pos = 0;
   int             m_ds = 0;
   int             m_wn = 0;
   logic [FCW-1:0] m_cnt = '0;
   logic [SYNC-1:0] m_sync = '0;

   always @(posedge sck or negedge rstn) begin : model
      int  len, n_phase, n_ds, n_wn;
      bit  en_s, running, fe;
      if (!rstn) begin
         m_phase <= 0; m_pos <= 0; m_ds <= 0; m_wn <= 0; m_cnt <= '0; m_sync <= '0;
      end else begin
         en_s    = m_sync[SYNC-1];
         running = (m_phase >= 2);
         len     = (m_ds + 1) * (m_wn + 1);
         fe      = running && (m_pos == len - 1);
         n_phase = m_phase; n_ds = m_ds; n_wn = m_wn;
         if (m_phase == 0) begin
            if (en_s) n_phase = 1;
         end else if (m_phase == 1) begin
            n_ds = int'(cfg_ds); n_wn = int'(cfg_wn);
            n_phase = en_s ? 2 : 0;
         end else if (m_phase == 2) begin
            if (!en_s) n_phase = fe ? 0 : 3;
            else if (fe) begin n_ds = int'(cfg_ds); n_wn = int'(cfg_wn); end
         end else begin
            if (en_s) n_phase = 2;
            else if (fe) n_phase = 0;
         end
         m_phase <= n_phase;
         m_ds    <= n_ds;
         m_wn    <= n_wn;
         m_pos   <= (running && !fe) ? m_pos + 1 : 0;
         m_cnt   <= m_cnt + (fe ? 1 : 0);
         m_sync  <= {m_sync[SYNC-2:0], cfg_en};
      end
   end

   always @(negedge sck) begin : compare
      bit running;
      int e_bit, e_slot, len;
      running = (m_phase >= 2);
      len     = (m_ds + 1) * (m_wn + 1);
      e_bit   = m_pos % (m_ds + 1);
      e_slot  = m_pos / (m_ds + 1);
      chk("ws_en",       int'(ws_en_o),       int'(running));
      chk("busy",        int'(busy_o),        int'(m_phase != 0));
      chk("shd_ds",      int'(shd_ds_o),      m_ds);
      chk("shd_wn",      int'(shd_wn_o),      m_wn);
      chk("bit",         int'(bit_o),         e_bit);
      chk("slot",        int'(slot_o),        e_slot);
      chk("slot_start",  int'(slot_start_o),  int'(running && e_bit == 0));
      chk("frame_start", int'(frame_start_o), int'(running && m_pos == 0));
      chk("frame_end",   int'(frame_end_o),   int'(running && m_pos == len - 1));
      chk("frame_cnt",   int'(frame_cnt_o),   int'(m_cnt));
   end

   initial begin : stim
      int n, fs, ss;
      int fc;
      bit held;

      #12 rstn = 1'b1;
      @(negedge sck);
      chk("reset_ws_en", int'(ws_en_o), 0);
      chk("reset_frame_cnt", int'(frame_cnt_o), 0);

      // Start: ds=15 wn=1
      #1 cfg_en = 1'b1;
      n = 0;
      while (!ws_en_o && n < 20) begin @(posedge sck); #1; n++; end
      chk("start_latency", n, SYNC + 2);
      chk("start_bit0", int'(bit_o), 0);
      chk("start_frame_start", int'(frame_start_o), 1);
      fs = 0; ss = 0;
      for (int i = 0; i < 96; i++) begin
         @(negedge sck);
         fs += int'(frame_start_o);
         ss += int'(slot_start_o);
      end
      @(posedge sck); #1;
      chk("frame_start_pulses", fs, 3);
      chk("slot_start_pulses", ss, 6);
      chk("frame_cnt_96", int'(frame_cnt_o), 3);

      // Stop mid-frame at bit 5 slot 0
      n = 0;
      while (!(bit_o == 5'd5 && slot_o == 3'd0) && n < 100) begin @(negedge sck); n++; end
      chk("reach_b5s0", int'(bit_o == 5'd5 && slot_o == 3'd0), 1);
      #1 cfg_en = 1'b0;
      n = 0;
      while (ws_en_o && n < 100) begin @(negedge sck); n++; end
      chk("stop_ws_en", int'(ws_en_o), 0);
      chk("stop_busy", int'(busy_o), 0);
      chk("stop_frame_cnt", int'(frame_cnt_o), 4);

      // Shadow update 15 -> 7
      #1 cfg_en = 1'b1;
      n = 0;
      while (!(ws_en_o && bit_o == 5'd3 && slot_o == 3'd1) && n < 100) begin @(negedge sck); n++; end
      chk("shd_before", int'(shd_ds_o), 15);
      #1 cfg_ds = 5'd7;
      n = 0;
      while (!frame_end_o && n < 40) begin @(negedge sck); n++; end
      chk("shd_at_fe", int'(shd_ds_o), 15);
      @(negedge sck);
      chk("shd_after_fe", int'(shd_ds_o), 7);
      chk("new_frame_start", int'(frame_start_o), 1);
      n = 1;
      while (!frame_end_o && n < 40) begin @(negedge sck); n++; end
      chk("short_frame_len", n, 16);

      // Cancel stop before frame end
      n = 0;
      while (!(bit_o == 5'd2 && slot_o == 3'd0) && n < 40) begin @(negedge sck); n++; end
      #1 cfg_en = 1'b0;
      repeat (3) @(negedge sck);
      #1 cfg_en = 1'b1;
      held = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge sck);
         if (!ws_en_o) held = 1'b0;
      end
      chk("cancel_ws_en_held", int'(held), 1);

      // Minimum frame ds=0 wn=0
      #1 cfg_ds = 5'd0; cfg_wn = 3'd0;
      n = 0;
      while (!frame_end_o && n < 40) begin @(negedge sck); n++; end
      @(negedge sck);
      chk("min_shd_ds", int'(shd_ds_o), 0);
      fc = int'(frame_cnt_o);
      for (int i = 1; i <= 5; i++) begin
         @(negedge sck);
         chk("min_fe", int'(frame_end_o), 1);
         chk("min_cnt_step", int'(frame_cnt_o), fc + i);
      end
      #1 cfg_en = 1'b0;
      n = 0;
      while (ws_en_o && n < 20) begin @(posedge sck); #1; n++; end
      chk("min_stop_latency", n, SYNC + 1);

      // Async reset at slot 2 bit 9
      @(negedge sck);
      #1 cfg_ds = 5'd31; cfg_wn = 3'd3; cfg_en = 1'b1;
      n = 0;
      while (!(ws_en_o && slot_o == 3'd2 && bit_o == 5'd9) && n < 200) begin @(negedge sck); n++; end
      chk("reach_s2b9", int'(slot_o == 3'd2 && bit_o == 5'd9), 1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_ws_en", int'(ws_en_o), 0);
      chk("rst_bit", int'(bit_o), 0);
      chk("rst_slot", int'(slot_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_frame_cnt", int'(frame_cnt_o), 0);
      chk("rst_shd_ds", int'(shd_ds_o), 0);
      repeat (2) @(negedge sck);
      #1 rstn = 1'b1;
      n = 0;
      while (!ws_en_o && n < 20) begin @(posedge sck); #1; n++; end
      chk("restart_latency", n, SYNC + 2);
      chk("restart_bit", int'(bit_o), 0);
      chk("restart_slot", int'(slot_o), 0);
      chk("restart_shd_ds", int'(shd_ds_o), 31);
      repeat (40) @(negedge sck);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2s_ws_ctrl.md
Name: i2s_ws_ctrl

Overview:
Start/stop sequencer and configuration shadow for the I2S WS generator, clocked in the SCK domain. Synchronizes the register-domain enable and gates the generator's ws_en cleanly on frame boundaries. Shadows data-size and word-count so the generator and serializer only see changes at frame boundaries. Mirrors the generator's bit/slot counters and emits slot/frame strobes for the I2S serializer/deserializer.

Parameters:
SYNC_STAGES, 2, flops in the cfg_en_i synchronizer (min 2)
FRAME_CNT_W, 16, width of free-running frame counter

Ports:
sck_i  in  1  I2S bit clock; all logic on posedge
rstn_i  in  1  reset, asynchronous, active-low
cfg_en_i  in  1  enable level from register domain (asynchronous to sck_i)
cfg_data_size_i  in  5  bits per slot minus 1 (register domain, quasi-static)
cfg_word_num_i  in  3  slots per frame minus 1 (register domain, quasi-static)
ws_en_o  out  1  enable to WS generator
shd_data_size_o  out  5  shadowed data size to generator/serializer
shd_word_num_o  out  3  shadowed word count to generator/serializer
bit_o  out  5  current bit index within slot (mirror of generator)
slot_o  out  3  current slot index within frame
slot_start_o  out  1  bit_o==0 while running
frame_start_o  out  1  bit_o==0 && slot_o==0 while running
frame_end_o  out  1  last bit of last slot while running
frame_cnt_o  out  FRAME_CNT_W  completed-frame count, wraps
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including shadows, counters, frame_cnt_o and synchronizer flops.
- en_s = cfg_en_i after SYNC_STAGES flops. No other cfg input is synchronized; shadows capture them only in START or at a frame end.
- States: IDLE, START, RUN, DRAIN.
- IDLE: bit/slot held at 0. When en_s=1, go to START.
- START: single cycle. Load shadows from cfg_*_i. Go to RUN if en_s=1, else IDLE.
- ws_en_o is a registered output, 1 exactly when state is RUN or DRAIN. First posedge with ws_en_o=1 is bit 0 of slot 0.
- RUN/DRAIN counting on each posedge, identical to the generator:
  - if bit==shd_data_size: bit<=0; then slot<=0 if slot==shd_word_num, else slot+1;
  - otherwise bit+1.
- Strobes are combinational from the counters and are gated by ws_en_o.
- fe = frame_end_o.
- RUN:
  - en_s=0 and !fe: go to DRAIN.
  - en_s=0 and fe: go to IDLE.
  - en_s=1 and fe: reload shadows from cfg_*_i; counters wrap to 0.
- DRAIN: counters continue.
  - en_s=1: return to RUN with no interruption and no shadow reload.
  - fe with en_s=0: go to IDLE.
- Stopping always happens after a complete frame. The generator samples ws_en=1 on the final edge and wraps its counters to 0, so it restarts aligned. The WS level after stop is not controlled by this block.
- frame_cnt_o increments on every fe edge, including the final one. It wraps at 2^FRAME_CNT_W. It is not cleared on restart, only by reset.
- Boundary cases:
  - data_size=0 and word_num=0: fe is asserted every cycle and shadows reload every cycle while RUN.
  - cfg changes mid-frame have no effect until the next fe.
  - en_s glitch shorter than SYNC_STAGES may be missed; this is accepted.
- Reset mid-operation: immediate return to the reset state; ws_en_o drops asynchronously.

Decomposition:
- i2s_pkg holds:
  - the state enum (IDLE=2'd0, START=2'd1, RUN=2'd2, DRAIN=2'd3);
  - DATA_SIZE_W=5 and WORD_NUM_W=3 constants.
- One sub-module: i2s_sync_flop — generic N-stage synchronizer with async active-low reset, reusable by the other I2S blocks.
- Counters and FSM stay in i2s_ws_ctrl.

Test Plan:
- Start: data_size=15, word_num=1, cfg_en_i 0->1.
  - ws_en_o rises SYNC_STAGES+2 edges later.
  - frame_start_o pulses every 32 cycles; slot_start_o every 16.
  - frame_cnt_o=3 after 96 running cycles.
- Stop mid-frame: drop cfg_en_i at bit 5 of slot 0 (same config).
  - DRAIN, then ws_en_o falls on the edge after frame_end_o; busy_o=0.
  - Exactly 1 additional frame counted.
- Shadow update: during RUN set data_size 15->7.
  - shd_data_size_o stays 15 until the fe edge, then 7.
  - Next frame is 16 cycles (word_num=1).
- Cancel stop: drop cfg_en_i, re-raise it before fe.
  - DRAIN->RUN; ws_en_o never deasserts; counters continuous.
- Minimum frame: data_size=0, word_num=0.
  - frame_end_o=1 every running cycle; frame_cnt_o +1 per cycle.
  - Stop completes on the first edge after en_s=0.
- Async reset at slot 2, bit 9 (data_size=31, word_num=3).
  - All outputs 0 immediately.
  - After release with cfg_en_i still 1, a clean restart from bit 0 / slot 0.
